// File: rtl/ram_frame_reader.sv
// ram_frame_reader: scans the 1-bit-per-pixel frame RAM from BASE_ADDR
// for NUM_PIXELS pixels and streams them out as MSB-first packed bytes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      begin a scan (IDLE only) / cancel a scan
//   address, wboolean RAM address and write enable (always 0)
//   rdata             RAM read data, bit 0 is the pixel
//   m_data, m_valid,
//   m_ready           packed byte stream toward the display path
//   busy, done        scan in progress / one-cycle end-of-scan pulse
//   byte_count        bytes accepted in the current or last scan
module ram_frame_reader #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned NUM_PIXELS = 57600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] address,
    output logic        wboolean,
    input  logic [31:0] rdata,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [16:0] NPIX     = 17'(NUM_PIXELS);
    localparam logic [16:0] LAST_PIX = 17'(NUM_PIXELS - 1);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [16:0] pix_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        done_q;
    logic [15:0] byte_cnt_q;

    logic [7:0]  shreg_d;
    logic        last_pix;
    logic        unused_rdata;

    assign shreg_d      = {shreg_q[6:0], rdata[0]};
    assign last_pix     = (pix_cnt_q == LAST_PIX);
    assign unused_rdata = ^rdata[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            pix_cnt_q  <= 17'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            m_data_q   <= 8'd0;
            m_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= 16'd0;
        end else if (abort && state_q != IDLE) begin
            // Abort beats a same-edge accept: the byte is dropped uncounted.
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        addr_q     <= BASE;
                        pix_cnt_q  <= 17'd0;
                        bit_idx_q  <= 3'd0;
                        byte_cnt_q <= 16'd0;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    shreg_q   <= shreg_d;
                    pix_cnt_q <= pix_cnt_q + 17'd1;
                    if (!last_pix) begin
                        addr_q <= addr_q + 32'd1;
                    end
                    if (bit_idx_q == 3'd7 || last_pix) begin
                        // Left-align a short final byte; stale bits fall off the top.
                        m_data_q  <= shreg_d << (3'd7 - bit_idx_q);
                        m_valid_q <= 1'b1;
                        bit_idx_q <= 3'd0;
                        state_q   <= SEND;
                    end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid_q  <= 1'b0;
                        byte_cnt_q <= byte_cnt_q + 16'd1;
                        state_q    <= (pix_cnt_q == NPIX) ? DONE : FETCH;
                    end
                end
                DONE: begin
                    // First DONE cycle raises done; second returns to IDLE.
                    done_q <= !done_q;
                    if (done_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign address    = addr_q;
    assign wboolean   = 1'b0;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_ram_frame_reader.sv
// tb_ram_frame_reader: directed bench for ram_frame_reader.
// Three instances: 16 px at 0, 11 px at 100, default full frame.
module tb_ram_frame_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        a_start, a_abort, a_wb, a_valid, a_ready, a_busy, a_done;
    logic [31:0] a_address, a_rdata;
    logic [7:0]  a_data;
    logic [15:0] a_bc;

    logic        b_start, b_abort, b_wb, b_valid, b_ready, b_busy, b_done;
    logic [31:0] b_address, b_rdata;
    logic [7:0]  b_data;
    logic [15:0] b_bc;

    logic        c_start, c_abort, c_wb, c_valid, c_ready, c_busy, c_done;
    logic [31:0] c_address, c_rdata;
    logic [7:0]  c_data;
    logic [15:0] c_bc;

    logic mem_a [0:255];
    logic mem_b [0:255];
    logic mem_c [0:57599];
    logic wb_seen = 1'b0;

    ram_frame_reader #(.BASE_ADDR(0), .NUM_PIXELS(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .address(a_address), .wboolean(a_wb), .rdata(a_rdata),
        .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready),
        .busy(a_busy), .done(a_done), .byte_count(a_bc)
    );

    ram_frame_reader #(.BASE_ADDR(100), .NUM_PIXELS(11)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .address(b_address), .wboolean(b_wb), .rdata(b_rdata),
        .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready),
        .busy(b_busy), .done(b_done), .byte_count(b_bc)
    );

    ram_frame_reader u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .address(c_address), .wboolean(c_wb), .rdata(c_rdata),
        .m_data(c_data), .m_valid(c_valid), .m_ready(c_ready),
        .busy(c_busy), .done(c_done), .byte_count(c_bc)
    );

    // RAM models: registered address, data updated on the following negedge.
    always @(negedge clk) begin
        a_rdata <= {31'd0, mem_a[a_address[7:0]]};
        b_rdata <= {31'd0, mem_b[b_address[7:0]]};
        c_rdata <= {31'd0, (c_address < 32'd57600) ? mem_c[c_address[15:0]] : 1'b0};
    end

    always @(posedge clk) begin
        if (a_wb || b_wb || c_wb) wb_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ckr_exp(input int idx);
        return (((idx / 30) % 2) != 0) ? 8'h55 : 8'hAA;
    endfunction

    initial begin
        logic [15:0] pat;
        int nbytes;
        int done_cyc;

        pat = 16'b1011_0001_1111_0000;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i < 16) ? pat[15 - i] : 1'b0;
            mem_b[i] = (i >= 100 && i <= 115) ? 1'b1 : 1'b0;
        end
        for (int i = 0; i < 57600; i++) begin
            mem_c[i] = (((i % 240) + (i / 240)) % 2) == 0;
        end
        a_rdata = 32'd0; b_rdata = 32'd0; c_rdata = 32'd0;
        a_start = 0; a_abort = 0; a_ready = 1;
        b_start = 0; b_abort = 0; b_ready = 1;
        c_start = 0; c_abort = 0; c_ready = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_addr", a_address, 32'd0);
        chk("rst_b_addr", b_address, 32'd0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_done", {31'd0, a_done}, 32'd0);
        chk("rst_a_data", {24'd0, a_data}, 32'd0);
        chk("rst_a_bc", {16'd0, a_bc}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Scan 1: 16 pixels, sink always ready
        a_start = 1; tick(); a_start = 0;
        chk("s1_busy", {31'd0, a_busy}, 32'd1);
        chk("s1_addr0", a_address, 32'd0);
        repeat (8) tick();
        chk("s1_v1", {31'd0, a_valid}, 32'd1);
        chk("s1_b1", {24'd0, a_data}, 32'hB1);
        chk("s1_addr8", a_address, 32'd8);
        tick();
        chk("s1_acc1", {31'd0, a_valid}, 32'd0);
        chk("s1_bc1", {16'd0, a_bc}, 32'd1);
        repeat (8) tick();
        chk("s1_v2", {31'd0, a_valid}, 32'd1);
        chk("s1_b2", {24'd0, a_data}, 32'hF0);
        chk("s1_addr15", a_address, 32'd15);
        tick();
        chk("s1_bc2", {16'd0, a_bc}, 32'd2);
        chk("s1_nodone", {31'd0, a_done}, 32'd0);
        tick();
        chk("s1_done", {31'd0, a_done}, 32'd1);
        chk("s1_busy_d", {31'd0, a_busy}, 32'd1);
        tick();
        chk("s1_done_end", {31'd0, a_done}, 32'd0);
        chk("s1_idle", {31'd0, a_busy}, 32'd0);
        tick();

        // Scan 2: back-pressure for 5 cycles on the first byte
        a_ready = 0;
        a_start = 1; tick(); a_start = 0;
        repeat (8) tick();
        chk("s2_v1", {31'd0, a_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_hold_v", {31'd0, a_valid}, 32'd1);
            chk("s2_hold_d", {24'd0, a_data}, 32'hB1);
            chk("s2_hold_a", a_address, 32'd8);
        end
        a_ready = 1;
        tick();
        chk("s2_bc1", {16'd0, a_bc}, 32'd1);
        repeat (8) tick();
        chk("s2_b2", {24'd0, a_data}, 32'hF0);
        tick();
        chk("s2_bc2", {16'd0, a_bc}, 32'd2);
        tick();
        chk("s2_done", {31'd0, a_done}, 32'd1);
        tick();
        chk("s2_idle", {31'd0, a_busy}, 32'd0);

        // Abort during second byte's FETCH
        a_start = 1; tick(); a_start = 0;
        repeat (9) tick();
        chk("ab_bc1", {16'd0, a_bc}, 32'd1);
        repeat (3) tick();
        a_abort = 1; tick(); a_abort = 0;
        chk("ab_busy", {31'd0, a_busy}, 32'd0);
        chk("ab_valid", {31'd0, a_valid}, 32'd0);
        chk("ab_bc", {16'd0, a_bc}, 32'd1);
        chk("ab_done", {31'd0, a_done}, 32'd0);
        tick();
        chk("ab_done2", {31'd0, a_done}, 32'd0);
        a_start = 1; tick(); a_start = 0;
        chk("ab_re_addr", a_address, 32'd0);
        chk("ab_re_bc", {16'd0, a_bc}, 32'd0);
        repeat (8) tick();
        chk("ab_re_b1", {24'd0, a_data}, 32'hB1);
        // Abort on the same edge as an accept: byte not counted
        a_abort = 1; tick(); a_abort = 0;
        chk("ab_acc_bc", {16'd0, a_bc}, 32'd0);
        chk("ab_acc_v", {31'd0, a_valid}, 32'd0);
        chk("ab_acc_busy", {31'd0, a_busy}, 32'd0);

        // start and abort together in IDLE
        a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0;
        chk("sa_idle", {31'd0, a_busy}, 32'd0);

        // Reset mid-SEND; start during scan ignored
        a_ready = 0;
        a_start = 1; tick(); a_start = 0;
        repeat (2) tick();
        a_start = 1; tick(); a_start = 0;
        chk("ign_start_addr", a_address, 32'd3);
        repeat (5) tick();
        chk("rs_pre_v", {31'd0, a_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_valid", {31'd0, a_valid}, 32'd0);
        chk("rs_data", {24'd0, a_data}, 32'd0);
        chk("rs_addr", a_address, 32'd0);
        chk("rs_busy", {31'd0, a_busy}, 32'd0);
        #1 rst_n = 1'b1;
        a_ready = 1;
        tick();
        chk("rs_stay_idle", {31'd0, a_busy}, 32'd0);

        // 11 pixels at 100, partial last byte
        b_start = 1; tick(); b_start = 0;
        chk("b_addr0", b_address, 32'd100);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("b_addr", b_address, 32'(100 + k));
        end
        chk("b_b1", {24'd0, b_data}, 32'hFF);
        repeat (4) tick();
        chk("b_v2", {31'd0, b_valid}, 32'd1);
        chk("b_b2", {24'd0, b_data}, 32'hE0);
        chk("b_addr_last", b_address, 32'd110);
        tick();
        chk("b_bc", {16'd0, b_bc}, 32'd2);
        tick();
        chk("b_done", {31'd0, b_done}, 32'd1);
        chk("b_addr_hold", b_address, 32'd110);
        tick();

        // Full default frame, checkerboard
        nbytes = 0;
        done_cyc = -1;
        c_start = 1; tick(); c_start = 0;
        for (int k = 1; k <= 64805; k++) begin
            tick();
            if (c_valid) begin
                chk("ckr_byte", {24'd0, c_data}, {24'd0, ckr_exp(nbytes)});
                nbytes++;
            end
            if (c_done && done_cyc < 0) done_cyc = k;
        end
        chk("ckr_nbytes", 32'(nbytes), 32'd7200);
        chk("ckr_done_cyc", 32'(done_cyc), 32'd64801);
        chk("ckr_bc", {16'd0, c_bc}, 32'd7200);
        chk("ckr_idle", {31'd0, c_busy}, 32'd0);

        chk("wb_never", {31'd0, wb_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_frame_reader.md
# ram_frame_reader

Bus initiator that scans the 1-bit-per-pixel frame RAM sequentially and streams its contents out as packed bytes. It drives the RAM's `address`/`wboolean` inputs and samples `rdata[0]`, then packs 8 consecutive pixels MSB-first into a byte. Bytes leave on a valid/ready stream toward the output/display path. It is the read-side counterpart to the pixel writer that fills the RAM.

## Interface
- `BASE_ADDR`, default 0: first pixel address read.
- `NUM_PIXELS`, default 57600: pixels per scan. `BASE_ADDR+NUM_PIXELS-1` must be ≤ 57599.
- `clk` input, 1: single clock, all state on posedge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: one-cycle request to begin a scan; sampled only in IDLE.
- `abort` input, 1: cancel the scan in progress.
- `address` output, 32: RAM address.
- `wboolean` output, 1: RAM write enable, constant 0.
- `rdata` input, 32: RAM read data; only bit 0 is used.
- `m_data` output, 8: packed pixel byte; the first pixel of the group is in bit 7.
- `m_valid` output, 1: `m_data` is valid.
- `m_ready` input, 1: the sink accepts the byte on this edge when `m_valid` is also 1.
- `busy` output, 1: high in FETCH, SEND or DONE.
- `done` output, 1: one-cycle pulse after the final byte is accepted.
- `byte_count` output, 16: bytes accepted in the current or last scan.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE
  - `start`=1: `address`←`BASE_ADDR`, `pix_cnt`←0, `bit_idx`←0, `byte_count`←0, go to FETCH.
- FETCH, one pixel per cycle
  - `shreg`←{`shreg[6:0]`, `rdata[0]`}, `pix_cnt`+1.
  - `address`+1, except on the last pixel, where it holds.
  - After `bit_idx`=7 or the last pixel:
    - `m_data`←byte left-aligned; pad missing low bits with 0.
    - `m_valid`←1, `bit_idx`←0, go to SEND.
- SEND
  - Hold `m_data`, `m_valid` and `address` until `m_ready`=1.
  - On the accept edge: `m_valid`←0, `byte_count`+1.
  - Then go to FETCH if pixels remain, else to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `address` holds its last value.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; `m_valid`←0 and `busy`←0 on that edge.
  - No `done` pulse. `byte_count` keeps bytes already accepted.
  - `abort` overrides a simultaneous `m_ready` accept; that byte is not counted.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins, stay IDLE.
- Partial last byte: `NUM_PIXELS` mod 8 = r ≠ 0 → final byte carries r pixels in bits 7..8-r, rest 0.
- Byte count per scan = ceil(`NUM_PIXELS`/8); 7200 at default.
- Reset, asynchronous, any state:
  - IDLE; `address`=0, `wboolean`=0, `m_data`=0, `m_valid`=0, `busy`=0, `done`=0, `byte_count`=0, `shreg`=0.

## Timing
- RAM read path
  - `address` is registered on posedge; the RAM updates `rdata` on the following negedge.
  - The block samples `rdata[0]` on the next posedge, so read latency is 1 cycle with no wait states.
  - On return from SEND, `rdata` already reflects the held `address`; the first FETCH edge is valid.
- Start-to-first-byte
  - `start` sampled at edge E0 → `address`=`BASE_ADDR` after E0.
  - Bits sampled at E1..E8; `m_valid`=1 after E8.
- With `m_ready` held 1, each byte takes 9 cycles (8 FETCH + 1 SEND).
  - Full default scan: `done` after edge E0+64801; `busy` falls the cycle after.
- `m_valid` never deasserts without an accept, except on `abort` or reset. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Test plan
- Reset, then `start` with `NUM_PIXELS`=16, RAM[0..15] = 1,0,1,1,0,0,0,1, 1,1,1,1,0,0,0,0, `m_ready`=1:
  - bytes 0xB1 then 0xF0; `done` pulses once; `byte_count`=2; `wboolean` never 1.
- Same scan with `m_ready` low for 5 cycles after the first `m_valid`:
  - 0xB1 held stable for those 5 cycles; `address` holds at 8; second byte still 0xF0.
- `NUM_PIXELS`=11, `BASE_ADDR`=100, RAM[100..110] all 1:
  - bytes 0xFF then 0xE0; `address` sequence 100..110, final held at 110.
- `abort` asserted during the 2nd byte's FETCH:
  - IDLE next cycle; `busy`=0; no `done`; `byte_count`=1. A new `start` then rescans from `BASE_ADDR`.
- `rst_n` pulsed low mid-SEND:
  - all outputs go to reset values immediately, without waiting for a clock edge; `start` pulses during the scan are ignored.
- Default 57600-pixel scan, `m_ready`=1, RAM with a checkerboard pattern:
  - 7200 bytes alternating 0xAA/0x55 per row parity as expected; `done` exactly 64801 edges after `start`.
